// File: rtl/data_mem_port_pkg.sv
// Shared types and helpers for the MEM-stage data memory port.
// Load/store funct3 encodings, port FSM states and access-size helpers.
package data_mem_port_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } dmem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_t;

    // Undefined encodings fall back to word accesses.
    function automatic access_size_t load_size(input logic [2:0] funct3);
        access_size_t sz;
        case (funct3)
            LB, LBU: sz = SZ_BYTE;
            LH, LHU: sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic access_size_t store_size(input logic [2:0] funct3);
        access_size_t sz;
        case (funct3)
            SB:      sz = SZ_BYTE;
            SH:      sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input access_size_t sz,
                                           input logic [1:0] off);
        logic mis;
        case (sz)
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/data_mem_port_load_extend.sv
// Load data alignment: picks byte/half/word out of the cache word
// and sign- or zero-extends it according to funct3.
module data_mem_port_load_extend
    import data_mem_port_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_en;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        sign_en  = ~funct3[2];
        case (load_size(funct3))
            SZ_BYTE: load_data = {{24{sign_en & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{sign_en & half_sel[15]}}, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/data_mem_port.sv
// MEM-stage data memory port: cache handshake, store formatting, load extend.
// Define MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of issuing them.
module data_mem_port
    import data_mem_port_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        data_mem_read,
    input  logic        data_mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall_out,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign
);

    dmem_state_t state_q, state_d;
    logic        dmem_read_q, dmem_read_d;
    logic        dmem_write_q, dmem_write_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic        is_read_q, is_read_d;
    logic        misalign_q, misalign_d;

    logic        req;
    logic        req_misaligned;
    logic [3:0]  st_be;
    logic [31:0] st_data;

    assign req = mem_valid & (data_mem_read | data_mem_write);

`ifdef MISALIGN_TRAP_EN
    access_size_t req_size;

    always_comb begin
        req_size = data_mem_read ? load_size(funct3) : store_size(funct3);
        req_misaligned = is_misaligned(req_size, addr[1:0]);
    end
`else
    assign req_misaligned = 1'b0;
`endif

    always_comb begin
        case (funct3)
            SB: begin
                st_be   = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            SH: begin
                st_be   = 4'b0011 << {addr[1], 1'b0};
                st_data = {2{wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            be_q         <= '0;
            rdata_q      <= '0;
            funct3_q     <= '0;
            offset_q     <= '0;
            is_read_q    <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmem_read_q  <= dmem_read_d;
            dmem_write_q <= dmem_write_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            be_q         <= be_d;
            rdata_q      <= rdata_d;
            funct3_q     <= funct3_d;
            offset_q     <= offset_d;
            is_read_q    <= is_read_d;
            misalign_q   <= misalign_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dmem_read_d  = dmem_read_q;
        dmem_write_d = dmem_write_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        be_d         = be_q;
        rdata_d      = rdata_q;
        funct3_d     = funct3_q;
        offset_d     = offset_q;
        is_read_d    = is_read_q;
        misalign_d   = misalign_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d      = req_misaligned ? DONE : ACCESS;
                    is_read_d    = data_mem_read;
                    funct3_d     = funct3;
                    offset_d     = addr[1:0];
                    misalign_d   = req_misaligned;
                    dmem_addr_d  = {addr[31:2], 2'b00};
                    dmem_read_d  = ~req_misaligned & data_mem_read;
                    dmem_write_d = ~req_misaligned & ~data_mem_read;
                    be_d         = data_mem_read ? 4'b0000 : st_be;
                    dmem_wdata_d = data_mem_read ? 32'h0 : st_data;
                end
            end
            ACCESS: begin
                if (dmem_resp) begin
                    state_d      = DONE;
                    rdata_d      = dmem_rdata;
                    dmem_read_d  = 1'b0;
                    dmem_write_d = 1'b0;
                end
            end
            // Never samples inputs here, so a held instruction is not re-issued.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_out  = 1'b0;
        load_valid = 1'b0;
        misalign   = 1'b0;
        unique case (state_q)
            IDLE:   stall_out = req;
            ACCESS: stall_out = 1'b1;
            DONE: begin
                load_valid = is_read_q & ~misalign_q;
                misalign   = misalign_q;
            end
            default: stall_out = 1'b0;
        endcase
    end

    assign dmem_read        = dmem_read_q;
    assign dmem_write       = dmem_write_q;
    assign dmem_addr        = dmem_addr_q;
    assign dmem_wdata       = dmem_wdata_q;
    assign dmem_byte_enable = be_q;

    data_mem_port_load_extend u_load_extend (
        .funct3    (funct3_q),
        .offset    (offset_q),
        .rdata     (rdata_q),
        .load_data (load_data)
    );

endmodule
